pmp_scan_ctrl: RTL

PMP_SCAN_CTRL -- requirements
Module: pmp_scan_ctrl

---
 rtl/pmp_scan_ctrl_pkg.sv | 30 +++
 rtl/addr_check_n.sv | 46 ++++
 rtl/pmp_scan_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/pmp_scan_ctrl_pkg.sv
// Shared encodings for the PMP scan controller: FSM states, pmpcfg layout,
// address-matching modes and access types.
package pmp_scan_ctrl_pkg;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SCAN = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  localparam logic [1:0] A_OFF   = 2'd0;
  localparam logic [1:0] A_TOR   = 2'd1;
  localparam logic [1:0] A_NA4   = 2'd2;
  localparam logic [1:0] A_NAPOT = 2'd3;

  localparam int CFG_R    = 0;
  localparam int CFG_W    = 1;
  localparam int CFG_X    = 2;
  localparam int CFG_A_LO = 3;
  localparam int CFG_A_HI = 4;
  localparam int CFG_L    = 7;

  // Bits 6:5 of pmpcfg are reserved and always read back as zero.
  localparam logic [7:0] CFG_WMASK = 8'h9F;

  localparam logic [1:0] ACC_R    = 2'd0;
  localparam logic [1:0] ACC_W    = 2'd1;
  localparam logic [1:0] ACC_X    = 2'd2;
  localparam logic [1:0] ACC_RSVD = 2'd3;

endpackage

// File: rtl/addr_check_n.sv
// Single-entry PMP address matcher: reports whether every byte of an access
// lies inside the region described by one pmpaddr/A-field pair.
module addr_check_n
  import pmp_scan_ctrl_pkg::*;
(
  input  logic [1:0]  a_i,
  input  logic [31:0] addr_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] pmpaddr_i,
  input  logic [31:0] pmpaddr_prev_i,
  output logic        match_o
);

  // 36-bit byte arithmetic so a 2^35-byte NAPOT region never wraps.
  logic [35:0] acc_lo, acc_hi, rgn_lo, rgn_hi, pa_ext, napot_mask;

  always_comb begin
    acc_lo     = {4'd0, addr_i};
    acc_hi     = acc_lo + (36'd1 << size_i);
    pa_ext     = {4'd0, pmpaddr_i};
    napot_mask = pa_ext ^ (pa_ext + 36'd1);
    rgn_lo     = '0;
    rgn_hi     = '0;
    case (a_i)
      A_TOR: begin
        rgn_lo = {2'd0, pmpaddr_prev_i, 2'd0};
        rgn_hi = {2'd0, pmpaddr_i, 2'd0};
      end
      A_NA4: begin
        rgn_lo = {2'd0, pmpaddr_i, 2'd0};
        rgn_hi = rgn_lo + 36'd4;
      end
      A_NAPOT: begin
        rgn_lo = (pa_ext & ~napot_mask) << 2;
        rgn_hi = rgn_lo + ((napot_mask + 36'd1) << 2);
      end
      default: begin
        rgn_lo = '0;
        rgn_hi = '0;
      end
    endcase
  end

  assign match_o = (a_i != A_OFF) && (acc_lo >= rgn_lo) && (acc_hi <= rgn_hi);

endmodule

// File: rtl/pmp_scan_ctrl.sv
// PMP checker that holds the pmpcfg/pmpaddr CSRs and scans entries one per
// cycle through a single shared matcher, returning fault and matched index.
module pmp_scan_ctrl
  import pmp_scan_ctrl_pkg::*;
#(
  parameter int NENT = 8,
  localparam int IW = $clog2(NENT)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          csr_we_i,
  input  logic          csr_sel_i,
  input  logic [IW-1:0] csr_idx_i,
  input  logic [31:0]   csr_wdata_i,
  output logic          csr_ready_o,
  output logic [31:0]   csr_rdata_o,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [31:0]   req_addr_i,
  input  logic [1:0]    req_size_i,
  input  logic [1:0]    req_acc_i,
  input  logic          req_mmode_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic          rsp_fault_o,
  output logic [IW:0]   rsp_idx_o
);

  state_t        state_q, state_d;
  logic [7:0]    cfg_q   [NENT];
  logic [7:0]    cfg_d   [NENT];
  logic [31:0]   paddr_q [NENT];
  logic [31:0]   paddr_d [NENT];
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   raddr_q, raddr_d;
  logic [1:0]    rsize_q, rsize_d;
  logic [1:0]    racc_q, racc_d;
  logic          rmmode_q, rmmode_d;
  logic          fault_q, fault_d;
  logic [IW:0]   ridx_q, ridx_d;

  logic [IW-1:0] prev_idx;
  logic [31:0]   prev_addr;
  logic          hit, perm_ok, hit_fault, miss_fault, addr_locked;

  assign prev_idx  = idx_q - 1'b1;
  assign prev_addr = (idx_q == '0) ? '0 : paddr_q[prev_idx];

  addr_check_n u_check (
    .a_i           (cfg_q[idx_q][CFG_A_HI:CFG_A_LO]),
    .addr_i        (raddr_q),
    .size_i        (rsize_q),
    .pmpaddr_i     (paddr_q[idx_q]),
    .pmpaddr_prev_i(prev_addr),
    .match_o       (hit)
  );

  always_comb begin
    case (racc_q)
      ACC_R:   perm_ok = cfg_q[idx_q][CFG_R];
      ACC_W:   perm_ok = cfg_q[idx_q][CFG_W];
      ACC_X:   perm_ok = cfg_q[idx_q][CFG_X];
      default: perm_ok = 1'b0;
    endcase
  end

  // M-mode bypasses unlocked entries; the reserved access type always faults.
  assign hit_fault  = (racc_q == ACC_RSVD) ? 1'b1 :
                      (rmmode_q && !cfg_q[idx_q][CFG_L]) ? 1'b0 : !perm_ok;
  assign miss_fault = (racc_q == ACC_RSVD) || !rmmode_q;

  // A locked TOR entry also freezes the pmpaddr below it (its lower bound).
  always_comb begin
    addr_locked = cfg_q[csr_idx_i][CFG_L];
    for (int i = 0; i < NENT - 1; i++) begin
      if (csr_idx_i == IW'(i) && cfg_q[i+1][CFG_L] &&
          cfg_q[i+1][CFG_A_HI:CFG_A_LO] == A_TOR)
        addr_locked = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    cfg_d    = cfg_q;
    paddr_d  = paddr_q;
    idx_d    = idx_q;
    raddr_d  = raddr_q;
    rsize_d  = rsize_q;
    racc_d   = racc_q;
    rmmode_d = rmmode_q;
    fault_d  = fault_q;
    ridx_d   = ridx_q;
    case (state_q)
      ST_IDLE: begin
        if (csr_we_i) begin
          if (!csr_sel_i && !cfg_q[csr_idx_i][CFG_L])
            cfg_d[csr_idx_i] = csr_wdata_i[7:0] & CFG_WMASK;
          if (csr_sel_i && !addr_locked)
            paddr_d[csr_idx_i] = csr_wdata_i;
        end else if (req_valid_i) begin
          raddr_d  = req_addr_i;
          rsize_d  = req_size_i;
          racc_d   = req_acc_i;
          rmmode_d = req_mmode_i;
          idx_d    = '0;
          state_d  = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (hit) begin
          fault_d = hit_fault;
          ridx_d  = {1'b0, idx_q};
          state_d = ST_RESP;
        end else if (idx_q == IW'(NENT - 1)) begin
          fault_d = miss_fault;
          ridx_d  = (IW+1)'(NENT);
          state_d = ST_RESP;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      for (int i = 0; i < NENT; i++) begin
        cfg_q[i]   <= '0;
        paddr_q[i] <= '0;
      end
      idx_q    <= '0;
      raddr_q  <= '0;
      rsize_q  <= '0;
      racc_q   <= '0;
      rmmode_q <= 1'b0;
      fault_q  <= 1'b0;
      ridx_q   <= '0;
    end else begin
      state_q  <= state_d;
      cfg_q    <= cfg_d;
      paddr_q  <= paddr_d;
      idx_q    <= idx_d;
      raddr_q  <= raddr_d;
      rsize_q  <= rsize_d;
      racc_q   <= racc_d;
      rmmode_q <= rmmode_d;
      fault_q  <= fault_d;
      ridx_q   <= ridx_d;
    end
  end

  assign csr_ready_o = (state_q == ST_IDLE);
  assign req_ready_o = (state_q == ST_IDLE) && !csr_we_i;
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_fault_o = fault_q;
  assign rsp_idx_o   = ridx_q;
  assign csr_rdata_o = csr_sel_i ? paddr_q[csr_idx_i] : {24'd0, cfg_q[csr_idx_i]};

endmodule
